// File: rtl/tone_player_pkg.sv
// Shared types and tables for tone_player: FSM states, octave-0
// half-period table at 12 MHz, rest codes and tick divider helper.
package tone_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam logic [3:0] REST_MIN = 4'd12;
  localparam logic [3:0] REST_MAX = 4'd15;

  // Half-period in cycles of C0..B0 at 12 MHz
  localparam logic [18:0] HP_TABLE [0:11] = '{
    19'd366972, 19'd346420, 19'd326975, 19'd308483,
    19'd291262, 19'd274851, 19'd259516, 19'd244898,
    19'd231125, 19'd218182, 19'd205903, 19'd194363
  };

  function automatic int unsigned tick_div(
    input int unsigned clk_hz,
    input int unsigned tick_hz
  );
    return clk_hz / tick_hz;
  endfunction

  function automatic logic [18:0] half_period(
    input logic [3:0] code,
    input logic [2:0] oct
  );
    if (code >= REST_MIN)
      return '0;
    return HP_TABLE[code] >> oct;
  endfunction

endpackage

// File: rtl/tone_player_tick_gen.sv
// Duration tick strobe: one-cycle pulse every DIV cycles,
// restarted from zero by clear.
module tick_gen #(
  parameter int unsigned DIV = 120000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic tick
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt;

  assign tick = (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt <= '0;
    else if (clear || tick)
      cnt <= '0;
    else
      cnt <= cnt + W'(1);
  end

endmodule

// File: rtl/tone_player.sv
// Square-wave note player with valid/ready command intake.
// Define TONE_PLAYER_GAP_EN for a one-tick silent gap after each note.
module tone_player #(
  parameter int unsigned CLK_HZ  = 12000000,
  parameter int unsigned TICK_HZ = 100
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       note_valid,
  output logic       note_ready,
  input  logic [3:0] note_code,
  input  logic [2:0] note_oct,
  input  logic [7:0] note_dur,
  output logic       speaker,
  output logic       busy,
  output logic       done
);

  import tone_pkg::*;

  localparam int unsigned DIV = tick_div(CLK_HZ, TICK_HZ);

  state_t      state;
  state_t      state_nx;
  logic        armed;
  logic        rest;
  logic [18:0] hp;
  logic [18:0] hp_cnt;
  logic [7:0]  dur;
  logic [7:0]  tcnt;
  logic        tick;
  logic        tclr;
  logic        accept;
  logic        play_end;

  assign note_ready = armed & (state == IDLE);
  assign accept     = note_valid & note_ready;
  assign busy       = (state != IDLE);
  assign play_end   = (state == PLAY) &
                      ((dur == 8'd0) |
                       (tick & (tcnt + 8'd1 == dur)));

`ifdef TONE_PLAYER_GAP_EN
  assign tclr = accept | play_end;
`else
  assign tclr = accept;
`endif

  tick_gen #(
    .DIV (DIV)
  ) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (tclr),
    .tick  (tick)
  );

  always_comb begin
    state_nx = state;
    done     = 1'b0;
    unique case (state)
      IDLE: if (accept) state_nx = PLAY;
      PLAY: if (play_end) begin
`ifdef TONE_PLAYER_GAP_EN
        state_nx = GAP;
`else
        state_nx = IDLE;
        done     = 1'b1;
`endif
      end
`ifdef TONE_PLAYER_GAP_EN
      GAP: if (tick) begin
        state_nx = IDLE;
        done     = 1'b1;
      end
`endif
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed   <= 1'b0;
      rest    <= 1'b0;
      hp      <= '0;
      hp_cnt  <= '0;
      dur     <= '0;
      tcnt    <= '0;
      speaker <= 1'b0;
    end else begin
      armed <= 1'b1;
      if (accept) begin
        rest    <= (note_code >= REST_MIN);
        hp      <= half_period(note_code, note_oct);
        dur     <= note_dur;
        hp_cnt  <= '0;
        tcnt    <= '0;
        speaker <= 1'b0;
      end else if (state == PLAY) begin
        if (play_end) begin
          speaker <= 1'b0;
        end else begin
          if (tick)
            tcnt <= tcnt + 8'd1;
          if (!rest) begin
            if (hp_cnt == hp - 19'd1) begin
              speaker <= ~speaker;
              hp_cnt  <= '0;
            end else begin
              hp_cnt <= hp_cnt + 19'd1;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_tone_player.sv
// Directed self-checking bench for tone_player, run with a
// shortened tick (2000 cycles) so whole notes fit the cycle budget.
module tb_tone_player;

  localparam int DIV = 2000;
`ifdef TONE_PLAYER_GAP_EN
  localparam int GAPC = DIV;
`else
  localparam int GAPC = 0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       note_valid = 1'b0;
  logic       note_ready;
  logic [3:0] note_code = '0;
  logic [2:0] note_oct = '0;
  logic [7:0] note_dur = '0;
  logic       speaker;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;

  tone_player #(
    .CLK_HZ  (12000000),
    .TICK_HZ (6000)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .note_valid (note_valid),
    .note_ready (note_ready),
    .note_code  (note_code),
    .note_oct   (note_oct),
    .note_dur   (note_dur),
    .speaker    (speaker),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  // Present one command, let it be accepted, then scramble the inputs.
  task automatic send(input logic [3:0] c, input logic [2:0] o,
                      input logic [7:0] d);
    note_code  = c;
    note_oct   = o;
    note_dur   = d;
    note_valid = 1'b1;
    step();
    note_valid = 1'b0;
    note_code  = 4'd5;
    note_oct   = 3'd0;
    note_dur   = 8'hff;
  endtask

  // Watch a note from its first PLAY cycle to its first IDLE cycle.
  task automatic run_note(input string tag, input int plen,
                          input int len, input int hp);
    int bad = 0;
    int nd = 0;
    int dat = -1;
    int blo = 0;
    int rdy = 0;
    int edges = 0;
    logic prev = 1'b0;
    for (int k = 0; k < len; k++) begin
      logic e;
      e = (hp != 0 && k < plen) ? 1'((k / hp) % 2) : 1'b0;
      if (speaker !== e) bad++;
      if (speaker && !prev) edges++;
      prev = speaker;
      if (done) begin
        nd++;
        dat = k;
      end
      if (!busy) blo++;
      if (note_ready) rdy++;
      step();
    end
    chk({tag, " speaker_err"}, bad, 0);
    chk({tag, " rise_edges"}, edges,
        (hp == 0) ? 0 : ((plen - 1) / hp + 1) / 2);
    chk({tag, " done_count"}, nd, 1);
    chk({tag, " done_cycle"}, dat, len - 1);
    chk({tag, " busy_low"}, blo, 0);
    chk({tag, " ready_busy"}, rdy, 0);
    chk({tag, " idle_speaker"}, int'(speaker), 0);
    chk({tag, " idle_busy"}, int'(busy), 0);
    chk({tag, " idle_done"}, int'(done), 0);
    chk({tag, " idle_ready"}, int'(note_ready), 1);
  endtask

  initial begin
    int acc;
    int nd;
    int viol;
    int a1;
    int a2;
    int qp;

    repeat (3) step();
    chk("rst speaker", int'(speaker), 0);
    chk("rst busy", int'(busy), 0);
    chk("rst done", int'(done), 0);
    chk("rst ready", int'(note_ready), 0);
    rst_n = 1'b1;
    step();
    chk("release ready", int'(note_ready), 1);

    // A7: half-period 218182 >> 7 = 1704
    send(4'd9, 3'd7, 8'd2);
    run_note("a7", 2 * DIV, 2 * DIV + GAPC, 1704);

    send(4'd12, 3'd0, 8'd3);
    run_note("rest", 3 * DIV, 3 * DIV + GAPC, 0);

    // C5: half-period 366972 >> 5 = 11467
    send(4'd0, 3'd5, 8'd0);
    run_note("dur0", 1, 1 + GAPC, 11467);

    qp = DIV + GAPC + 1;
    acc = 0;
    nd = 0;
    viol = 0;
    a1 = -1;
    a2 = -1;
    note_code  = 4'd9;
    note_oct   = 3'd7;
    note_dur   = 8'd1;
    note_valid = 1'b1;
    for (int k = 0; k < 3 * qp + 20; k++) begin
      if (busy && note_ready) viol++;
      if (done) nd++;
      if (note_valid && note_ready) begin
        acc++;
        if (acc == 1) a1 = k;
        if (acc == 2) a2 = k;
      end
      step();
      if (acc == 3) note_valid = 1'b0;
    end
    note_valid = 1'b0;
    chk("queue accepts", acc, 3);
    chk("queue done", nd, 3);
    chk("queue ready_busy", viol, 0);
    chk("queue spacing", a2 - a1, qp);

    send(4'd9, 3'd7, 8'd2);
    nd = 0;
    for (int k = 0; k < 1800; k++) begin
      if (done) nd++;
      step();
    end
    chk("midrst speaker_before", int'(speaker), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst speaker", int'(speaker), 0);
    chk("midrst busy", int'(busy), 0);
    chk("midrst done", int'(done), 0);
    chk("midrst ready", int'(note_ready), 0);
    repeat (5) begin
      step();
      if (done) nd++;
    end
    chk("midrst no_done", nd, 0);
    rst_n = 1'b1;
    step();
    chk("midrst release_ready", int'(note_ready), 1);
    chk("midrst release_busy", int'(busy), 0);

`ifdef TONE_PLAYER_GAP_EN
    // B7: half-period 194363 >> 7 = 1518, then one silent tick
    send(4'd11, 3'd7, 8'd1);
    run_note("b7gap", DIV, 2 * DIV, 1518);
`endif

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/tone_player.md
TONE_PLAYER -- requirements
Module: tone_player

Interface
REQ-001 Parameter CLK_HZ, default 12000000, system clock frequency in Hz.
REQ-002 Parameter TICK_HZ, default 100, duration tick rate (10 ms per tick).
REQ-003 clk  input  1  system clock, rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 note_valid  input  1  upstream sequencer presents a note command.
REQ-006 note_ready  output  1  block can accept a command.
REQ-007 note_code  input  4  0..11 = C..B semitone; 12..15 = rest.
REQ-008 note_oct  input  3  octave 0..7.
REQ-009 note_dur  input  8  duration in ticks.
REQ-010 speaker  output  1  square-wave audio output.
REQ-011 busy  output  1  high while a command is playing.
REQ-012 done  output  1  one-cycle pulse when a command completes.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, PLAY and GAP; GAP is reachable only when TONE_PLAYER_GAP_EN is defined.
REQ-014 note_ready SHALL be 1 only in IDLE; a command is accepted on a clk edge with note_valid & note_ready, and all fields are registered at that edge.
REQ-015 On acceptance the FSM SHALL enter PLAY on the next cycle, with the tick counter and half-period counter cleared and speaker = 0.
REQ-016 Half-period in cycles SHALL be HP_TABLE[note_code] >> note_oct, where HP_TABLE holds 19-bit octave-0 values for CLK_HZ = 12 MHz (C0 = 366972 ... A0 = 218182).
REQ-017 In PLAY, for a tone note, speaker SHALL toggle each time the half-period counter reaches half-period - 1; the counter then wraps to 0.
REQ-018 For a rest (codes 12..15), speaker SHALL stay 0 for the whole duration.
REQ-019 PLAY SHALL last exactly note_dur ticks, with one tick = CLK_HZ/TICK_HZ cycles counted from PLAY entry.
REQ-020 note_dur = 0 SHALL complete immediately: done pulses in the first PLAY cycle and speaker never rises.
REQ-021 At the end of PLAY, speaker SHALL be forced to 0, then the FSM goes to GAP (macro defined) or to IDLE with done = 1 for that cycle (macro undefined).
REQ-022 busy SHALL be 1 in PLAY and GAP and 0 in IDLE.
REQ-023 A new command SHALL be accepted no earlier than the cycle after done; note_valid held high gives back-to-back notes separated by one IDLE cycle.
REQ-024 Changes to inputs while busy SHALL have no effect on the note in progress.

Reset
REQ-025 While rst_n = 0, the FSM SHALL be IDLE, all counters 0, speaker = 0, busy = 0, done = 0 and note_ready = 0.
REQ-026 note_ready SHALL assert on the first clk edge after rst_n is released.
REQ-027 If reset asserts mid-note, output SHALL stop immediately and the note SHALL be discarded, with no done pulse.

Configuration
REQ-028 With TONE_PLAYER_GAP_EN defined, after each PLAY the FSM SHALL spend exactly one tick in GAP with speaker = 0, and done SHALL pulse on GAP exit.
REQ-029 Without TONE_PLAYER_GAP_EN, GAP logic SHALL be absent and done SHALL pulse on PLAY exit.

Structure
REQ-030 Package tone_pkg SHALL hold: the state enum, HP_TABLE (12 entries x 19 bits), the REST code range, and a TICK_DIV function of CLK_HZ/TICK_HZ.
REQ-031 Sub-module tick_gen SHALL produce a one-cycle tick strobe every CLK_HZ/TICK_HZ cycles, restartable by a clear input asserted on PLAY entry.

Verification
REQ-032 Reset, then accept A4 (code 9, oct 4, dur 2): speaker toggles every 13636 cycles; done pulses 240000 cycles after PLAY entry; speaker = 0 afterwards.
REQ-033 Rest (code 12, dur 3): speaker stays 0 for 360000 cycles; busy = 1 throughout; one done pulse.
REQ-034 note_dur = 0 with C5: done is seen in the cycle after acceptance; no speaker edge.
REQ-035 note_valid held high with 3 queued notes: exactly 3 accepts, 3 done pulses, and note_ready = 0 whenever busy = 1.
REQ-036 Assert rst_n low 50000 cycles into a note: speaker, busy and done are 0 asynchronously; no done pulse; after release note_ready = 1.
REQ-037 With TONE_PLAYER_GAP_EN, B7 (code 11, oct 7, dur 1): done at 240000 cycles after PLAY entry; speaker = 0 during the final 120000 cycles.
